// File: rtl/ialu_result_collector.sv
// Integer ALU result collector: tracks the issued op's unit done(s), encodes the class, presents one result.
// Latency: WB_Valid rises the cycle after the last required done is sampled (2 cycles for single-cycle units).
// Backpressure: one op in flight; Issue_Ready low from issue until the WB_Valid/WB_Ready handshake completes.
//
// Optional feature: define IALU_TIMEOUT_EN to force completion after TIMEOUT WAIT cycles
// (WB_Result = 0, WB_Taken = 0, one-cycle Err_Timeout pulse). Undefined: WAIT never times out.
//
// Ports:
//   CLK, rst_n          clock, asynchronous active-low reset
//   Issue_Valid         op issued this cycle (ignored unless Issue_Ready)
//   IALU_Ctrl[2:0]      op class (000 ADD_SUB .. 110 BRANCH, 111 idle)
//   Issue_Ready         collector idle and able to accept an op
//   Unit_Done[7:0]      per-unit done pulses, bit k = class code k (bit 7 unused)
//   Unit_Result         flattened unit results, unit k at [k*XLEN +: XLEN]
//   Branch_Taken        branch outcome, qualified by Unit_Done[6]
//   WB_Valid/WB_Ready   writeback handshake
//   WB_Result/Unit/Taken captured result, encoded class, branch outcome
//   Err_Spurious        sticky flag: a done arrived outside the pending mask
//   Err_Timeout         one-cycle pulse on forced completion
module ialu_result_collector #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              Issue_Valid,
  input  logic [2:0]        IALU_Ctrl,
  output logic              Issue_Ready,
  input  logic [7:0]        Unit_Done,
  input  logic [8*XLEN-1:0] Unit_Result,
  input  logic              Branch_Taken,
  output logic              WB_Valid,
  input  logic              WB_Ready,
  output logic [XLEN-1:0]   WB_Result,
  output logic [2:0]        WB_Unit,
  output logic              WB_Taken,
  output logic              Err_Spurious,
  output logic              Err_Timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [2:0] CODE_BRANCH = 3'b110;
  localparam logic [2:0] CODE_NONE   = 3'b111;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_pend;
  logic [2:0]        r_exp_code;
  logic [XLEN-1:0]   r_wb_result;
  logic              r_wb_taken;
  logic              r_wb_valid;
  logic              r_err_spur;
  logic              r_err_to;

  logic              w_issue;
  logic [7:0]        w_issue_mask;
  logic [7:0]        w_hit;
  logic [7:0]        w_pend_clr;
  logic              w_spur;
  logic              w_is_br;
  logic [2:0]        w_data_idx;
  logic              w_data_hit;
  logic              w_taken_hit;
  logic              w_to_cond;
  logic              w_to_fire;
  logic [XLEN-1:0]   w_slices [8];

  for (genvar k = 0; k < 8; k++) begin : g_slice
    assign w_slices[k] = Unit_Result[k*XLEN +: XLEN];
  end

  assign w_issue = (r_state == S_IDLE) && Issue_Valid && (IALU_Ctrl != CODE_NONE);

  // A branch needs both the target address (ADD_SUB) and the outcome (BRANCH unit).
  assign w_issue_mask = (IALU_Ctrl == CODE_BRANCH) ? 8'h41 : (8'h01 << IALU_Ctrl);

  // The pending mask is zero outside WAIT, so any done seen in IDLE/HOLD is spurious.
  assign w_hit      = Unit_Done & r_pend;
  assign w_pend_clr = r_pend & ~Unit_Done;
  assign w_spur     = |(Unit_Done & ~r_pend);

  // The data word of a branch is the ADD_SUB target, not the BRANCH unit's slice.
  assign w_is_br     = (r_exp_code == CODE_BRANCH);
  assign w_data_idx  = w_is_br ? 3'd0 : r_exp_code;
  assign w_data_hit  = w_hit[w_data_idx];
  assign w_taken_hit = w_is_br && w_hit[6];

`ifdef IALU_TIMEOUT_EN
  localparam int            CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_M1  = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Counts WAIT cycles; saturates rather than wrapping.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= '0;
    end else if ((r_state == S_WAIT) && (r_cnt != TO_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires on the edge where the counter reaches TIMEOUT.
  assign w_to_cond = (r_cnt == TO_M1);
`else
  assign w_to_cond = 1'b0;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A done that empties the mask wins over a timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_to_fire   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_pend_clr == 8'h00) begin
          w_state_nxt = S_HOLD;
        end else if (w_to_cond) begin
          w_state_nxt = S_HOLD;
          w_to_fire   = 1'b1;
        end
      end
      S_HOLD: begin
        if (WB_Ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= '0;
      r_exp_code  <= '0;
      r_wb_result <= '0;
      r_wb_taken  <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_err_spur  <= 1'b0;
      r_err_to    <= 1'b0;
    end else begin
      r_err_to <= w_to_fire;
      if (w_spur) begin
        r_err_spur <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_exp_code <= IALU_Ctrl;
            r_pend     <= w_issue_mask;
            r_wb_taken <= 1'b0;
          end
        end
        S_WAIT: begin
          if (w_to_fire) begin
            r_pend      <= '0;
            r_wb_result <= '0;
            r_wb_taken  <= 1'b0;
            r_wb_valid  <= 1'b1;
          end else begin
            r_pend <= w_pend_clr;
            if (w_data_hit) begin
              r_wb_result <= w_slices[w_data_idx];
            end
            if (w_taken_hit) begin
              r_wb_taken <= Branch_Taken;
            end
            if (w_pend_clr == 8'h00) begin
              r_wb_valid <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (WB_Ready) begin
            r_wb_valid <= 1'b0;
          end
        end
        default: begin
          r_pend <= '0;
        end
      endcase
    end
  end

  assign Issue_Ready  = (r_state == S_IDLE);
  assign WB_Valid     = r_wb_valid;
  assign WB_Result    = r_wb_result;
  assign WB_Unit      = r_exp_code;
  assign WB_Taken     = r_wb_taken;
  assign Err_Spurious = r_err_spur;
  assign Err_Timeout  = r_err_to;

endmodule

// File: tb/tb_ialu_result_collector.sv
// Randomized bench for ialu_result_collector with a transaction-level reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
// The timeout expectation follows the IALU_TIMEOUT_EN macro of the build.
module tb_ialu_result_collector;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 8;
`ifdef IALU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              rst_n;
  logic              Issue_Valid;
  logic [2:0]        IALU_Ctrl;
  logic              Issue_Ready;
  logic [7:0]        Unit_Done;
  logic [8*XLEN-1:0] Unit_Result;
  logic              Branch_Taken;
  logic              WB_Valid;
  logic              WB_Ready;
  logic [XLEN-1:0]   WB_Result;
  logic [2:0]        WB_Unit;
  logic              WB_Taken;
  logic              Err_Spurious;
  logic              Err_Timeout;

  int n_tests = 0;
  int n_fail  = 0;
  bit m_spur  = 1'b0;

  ialu_result_collector #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .Issue_Valid  (Issue_Valid),
    .IALU_Ctrl    (IALU_Ctrl),
    .Issue_Ready  (Issue_Ready),
    .Unit_Done    (Unit_Done),
    .Unit_Result  (Unit_Result),
    .Branch_Taken (Branch_Taken),
    .WB_Valid     (WB_Valid),
    .WB_Ready     (WB_Ready),
    .WB_Result    (WB_Result),
    .WB_Unit      (WB_Unit),
    .WB_Taken     (WB_Taken),
    .Err_Spurious (Err_Spurious),
    .Err_Timeout  (Err_Timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic rand_results();
    for (int k = 0; k < 8; k++) begin
      Unit_Result[k*XLEN +: XLEN] = $urandom;
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    m_spur = 1'b0;
    chk("rst_issue_rdy", Issue_Ready, 1'b1);
    chk("rst_wb_valid", WB_Valid, 1'b0);
    chk("rst_wb_result", WB_Result, '0);
    chk("rst_wb_unit", WB_Unit, 3'd0);
    chk("rst_wb_taken", WB_Taken, 1'b0);
    chk("rst_err_spur", Err_Spurious, 1'b0);
    chk("rst_err_to", Err_Timeout, 1'b0);
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  // One op from issue to handshake. t_main: WAIT-cycle index of the data done,
  // t_br: index of the BRANCH done, spur_t/spur_k: a directed stray done.
  task automatic run_op(input logic [2:0] code, input int t_main, input int t_br,
                        input int stall, input bit spur_en, input int spur_t,
                        input int spur_k, input int max_cyc, output bit completed);
    logic [7:0]      pend;
    logic [7:0]      dn;
    logic [XLEN-1:0] exp_res;
    bit              exp_tk;
    bit              to_f;
    int              wc;
    int              idx;
    int              sidx;

    pend      = (code == 3'd6) ? 8'h41 : (8'h01 << code);
    idx       = (code == 3'd6) ? 0 : int'(code);
    exp_res   = '0;
    exp_tk    = 1'b0;
    completed = 1'b0;
    to_f      = 1'b0;

    Issue_Valid = 1'b1;
    IALU_Ctrl   = code;
    Unit_Done   = '0;
    rand_results();
    @(negedge CLK);
    Issue_Valid = 1'b0;
    chk("issue_rdy_after_issue", Issue_Ready, 1'b0);
    chk("wb_valid_after_issue", WB_Valid, 1'b0);

    wc = 0;
    while (!completed && wc < max_cyc) begin
      dn = '0;
      for (int k = 0; k < 8; k++) begin
        if (pend[k] && (((k == 6) ? t_br : t_main) == wc)) dn[k] = 1'b1;
      end
      if (spur_en && $urandom_range(3) == 0) begin
        sidx = $urandom_range(7);
        if (!pend[sidx]) dn[sidx] = 1'b1;
      end
      if (wc == spur_t) dn[spur_k] = 1'b1;
      rand_results();
      Branch_Taken = 1'($urandom);
      Issue_Valid  = 1'($urandom);
      IALU_Ctrl    = 3'($urandom);
      WB_Ready     = 1'($urandom);
      Unit_Done    = dn;

      if (|(dn & ~pend)) m_spur = 1'b1;
      if (dn[idx] && pend[idx]) exp_res = Unit_Result[idx*XLEN +: XLEN];
      if (code == 3'd6 && dn[6] && pend[6]) exp_tk = Branch_Taken;
      pend = pend & ~dn;
      wc++;
      to_f = 1'b0;
      if (pend == 8'h00) begin
        completed = 1'b1;
      end else if (TO_EN && wc == TIMEOUT) begin
        completed = 1'b1;
        to_f      = 1'b1;
        exp_res   = '0;
        exp_tk    = 1'b0;
      end

      @(negedge CLK);
      Unit_Done   = '0;
      Issue_Valid = 1'b0;
      WB_Ready    = 1'b0;
      chk("wait_wb_valid", WB_Valid, completed);
      chk("wait_err_to", Err_Timeout, to_f);
      chk("wait_err_spur", Err_Spurious, m_spur);
      chk("wait_issue_rdy", Issue_Ready, 1'b0);
    end
    if (!completed) return;

    chk("wb_result", WB_Result, exp_res);
    chk("wb_unit", WB_Unit, code);
    chk("wb_taken", WB_Taken, exp_tk);

    for (int s = 0; s < stall; s++) begin
      WB_Ready    = 1'b0;
      Issue_Valid = 1'($urandom);
      IALU_Ctrl   = 3'($urandom);
      rand_results();
      if (spur_en && $urandom_range(3) == 0) begin
        Unit_Done = 8'h01 << $urandom_range(7);
        m_spur = 1'b1;
      end
      @(negedge CLK);
      Unit_Done   = '0;
      Issue_Valid = 1'b0;
      chk("hold_wb_valid", WB_Valid, 1'b1);
      chk("hold_issue_rdy", Issue_Ready, 1'b0);
      chk("hold_wb_result", WB_Result, exp_res);
      chk("hold_wb_unit", WB_Unit, code);
      chk("hold_wb_taken", WB_Taken, exp_tk);
      chk("hold_err_to", Err_Timeout, 1'b0);
      chk("hold_err_spur", Err_Spurious, m_spur);
    end

    WB_Ready = 1'b1;
    @(negedge CLK);
    WB_Ready = 1'b0;
    chk("hs_wb_valid", WB_Valid, 1'b0);
    chk("hs_issue_rdy", Issue_Ready, 1'b1);
    chk("hs_err_to", Err_Timeout, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n        = 1'b0;
    Issue_Valid  = 1'b0;
    IALU_Ctrl    = 3'b111;
    Unit_Done    = '0;
    Unit_Result  = '0;
    Branch_Taken = 1'b0;
    WB_Ready     = 1'b0;

    #12;
    chk("reset_issue_rdy", Issue_Ready, 1'b1);
    chk("reset_wb_valid", WB_Valid, 1'b0);
    chk("reset_wb_result", WB_Result, '0);
    chk("reset_wb_unit", WB_Unit, 3'd0);
    chk("reset_err_spur", Err_Spurious, 1'b0);
    chk("reset_err_to", Err_Timeout, 1'b0);
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);

    // Idle code is not an issue.
    Issue_Valid = 1'b1;
    IALU_Ctrl   = 3'b111;
    @(negedge CLK);
    Issue_Valid = 1'b0;
    chk("idle_code_issue_rdy", Issue_Ready, 1'b1);
    chk("idle_code_wb_valid", WB_Valid, 1'b0);

    // Single-cycle ADD_SUB, long DIV with stall, branch dones in three orders.
    run_op(3'd0, 0, 0, 0, 1'b0, -1, 0, 20, ok);
    run_op(3'd2, 32, 0, 3, 1'b0, -1, 0, 200, ok);
    run_op(3'd6, 2, 0, 1, 1'b0, -1, 0, 20, ok);
    run_op(3'd6, 0, 0, 0, 1'b0, -1, 0, 20, ok);
    run_op(3'd6, 0, 3, 2, 1'b0, -1, 0, 20, ok);
    // SET with a stray LOGIC done mid-WAIT.
    run_op(3'd3, 2, 0, 1, 1'b0, 1, 4, 20, ok);
    chk("spur_sticky", Err_Spurious, 1'b1);
    // Done arriving on the last permitted WAIT cycle completes normally.
    run_op(3'd1, TIMEOUT - 1, 0, 0, 1'b0, -1, 0, 20, ok);

    // Reset in the middle of a MUL wait, then a late MUL done.
    Issue_Valid = 1'b1;
    IALU_Ctrl   = 3'd1;
    @(negedge CLK);
    Issue_Valid = 1'b0;
    @(negedge CLK);
    pulse_reset();
    Unit_Done = 8'h02;
    @(negedge CLK);
    Unit_Done = '0;
    m_spur = 1'b1;
    chk("late_done_spur", Err_Spurious, 1'b1);
    chk("late_done_wb_valid", WB_Valid, 1'b0);
    run_op(3'd1, 1, 0, 0, 1'b0, -1, 0, 20, ok);

    // SHIFT with no done: forced completion or indefinite WAIT.
    run_op(3'd5, 100000, 0, 1, 1'b0, -1, 0, 100, ok);
    chk("timeout_completed", ok, TO_EN);
    if (!ok) pulse_reset();

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(9) == 0) begin
        Issue_Valid = 1'b1;
        IALU_Ctrl   = 3'b111;
        @(negedge CLK);
        Issue_Valid = 1'b0;
        chk("rand_idle_issue_rdy", Issue_Ready, 1'b1);
      end
      run_op(3'($urandom_range(6)), $urandom_range(4), $urandom_range(4),
             $urandom_range(3), 1'b1, -1, 0, 20, ok);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ialu_result_collector.md
# ialu_result_collector

Completion tracker and result encoder on the return side of the integer ALU. The control-to-unit decoder fans a 3-bit op class out to one-hot unit enables; this block waits for the selected functional unit(s) to report done and encodes the one-hot completion back into the same 3-bit class code. It then presents a single registered result to writeback under a valid/ready handshake. It holds exactly one op in flight, so multi-cycle units (MUL, DIV) stall issue until writeback accepts.

## Interface
- XLEN, 32, datapath width.
- TIMEOUT, 64, max WAIT cycles before forced completion; used only when IALU_TIMEOUT_EN is defined.
- CLK  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- Issue_Valid  in  1  op issued this cycle.
- IALU_Ctrl  in  3  op class: 000 ADD_SUB, 001 MUL, 010 DIV, 011 SET, 100 LOGIC, 101 SHIFT, 110 BRANCH, 111 idle.
- Issue_Ready  out  1  collector can accept an op.
- Unit_Done  in  8  per-unit done pulses; bit k corresponds to class code k; bit 7 unused.
- Unit_Result  in  8*XLEN  flattened results; unit k occupies Unit_Result[k*XLEN +: XLEN].
- Branch_Taken  in  1  branch outcome, sampled with Unit_Done[6].
- WB_Valid  out  1  result available.
- WB_Ready  in  1  writeback accepts.
- WB_Result  out  XLEN  captured result.
- WB_Unit  out  3  encoded class of the completed op.
- WB_Taken  out  1  branch outcome; 0 for non-branch ops.
- Err_Spurious  out  1  sticky: a done arrived that was not expected.
- Err_Timeout  out  1  one-cycle pulse on forced completion.

## Operation
- Three states: IDLE, WAIT, HOLD. Issue_Ready = (state == IDLE).
- IDLE, on Issue_Valid with IALU_Ctrl != 111:
  - Capture the code into exp_code.
  - Set the pending mask: bit exp_code for codes 000–101; bits 0 and 6 for 110.
  - Clear WB_Taken and the timeout counter. Go to WAIT.
- IDLE, on Issue_Valid with IALU_Ctrl == 111: ignored, stay in IDLE.
- WAIT, each cycle, for every pending bit k with Unit_Done[k] = 1:
  - Clear pending bit k.
  - k == exp_code, or k == 0 for a branch: latch Unit_Result slice k into WB_Result. For a branch, WB_Result is the ADD_SUB target address.
  - k == 6: latch Branch_Taken into WB_Taken.
- WAIT → HOLD when the pending mask becomes zero. The two branch dones may arrive in the same cycle or in either order across cycles.
- Any Unit_Done bit set outside the pending mask, in any state, sets Err_Spurious. That done is otherwise ignored and does not affect data. Err_Spurious clears only on reset.
- HOLD: WB_Valid = 1; WB_Result, WB_Unit (= exp_code) and WB_Taken stay stable. When WB_Ready = 1, go to IDLE.
- Issue_Valid while Issue_Ready = 0 is ignored. The issuer must hold the op.
- Reset, asynchronous and taking effect at any time, including mid-WAIT: state IDLE, pending mask 0, exp_code 000, counter 0. All outputs go to 0 except Issue_Ready, which goes to 1. A done arriving after reset is counted as spurious.

## Timing
- Issue accepted at edge N; earliest done sampled at edge N+1; WB_Valid asserts the cycle after the last required done is sampled.
- Single-cycle unit: 2 cycles from issue to WB_Valid.
- Handshake completes on the edge where WB_Valid & WB_Ready. Issue_Ready rises the following cycle, so back-to-back ops take at least 3 cycles each.
- All outputs are registered except Issue_Ready, which is decoded from the state register.
- Timeout counter width is $clog2(TIMEOUT+1). It does not wrap and saturates at TIMEOUT.

## Configuration
- IALU_TIMEOUT_EN defined:
  - The counter increments every WAIT cycle.
  - When it reaches TIMEOUT with the pending mask still non-zero, force HOLD with WB_Result = 0 and WB_Taken = 0, and pulse Err_Timeout for one cycle.
  - A done arriving on the same cycle the timeout fires takes priority: normal completion, no pulse.
- IALU_TIMEOUT_EN undefined: no counter logic; WAIT lasts indefinitely. Err_Timeout is tied to 0.

## Test plan
- Reset, then issue 000 with done[0] the next cycle and slice 0 = 0x0000_0005 → WB_Valid 2 cycles after issue; WB_Result 0x5; WB_Unit 000; WB_Taken 0.
- Issue 010; done[2] 33 cycles later with 0xFFFF_FFFE; WB_Ready held low 3 cycles → Issue_Ready low throughout; WB outputs stable during the stall; IDLE the cycle after WB_Ready.
- Issue 110; done[6] with Branch_Taken = 1, then done[0] 2 cycles later with 0x0000_1000 → WB_Result 0x1000, WB_Taken 1, WB_Unit 110. Repeat with both dones in the same cycle → same result.
- Issue 011 and also pulse done[4] during WAIT → Err_Spurious = 1 and stays set; the result comes from slice 3 only.
- Issue 001 and assert rst_n low mid-WAIT → outputs reset immediately; a later done[1] sets Err_Spurious; a new issue then completes normally.
- With IALU_TIMEOUT_EN and TIMEOUT = 8: issue 101 with no done → after 8 WAIT cycles, WB_Valid with WB_Result 0 and a single Err_Timeout pulse. Without the macro → still in WAIT after 100 cycles.
